mem_bus_arbiter: RTL and testbench

Arbitrates the CPU's instruction-fetch port and data-access port onto one shared SRAM-like memory bus with a single outstanding transaction. Produces the per-port `imem_busy` / `dmem_busy` indications consumed by the hazard unit through `busy_ok`, and returns read data to the requesting stage. Sits between the pipeline's F/M stages and the cache/AXI bridge.

---
 rtl/mem_bus_arbiter_pkg.sv | 29 ++
 rtl/mem_bus_arbiter_if.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 91 +++++++++
 tb/tb_mem_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared CPU definitions: arbiter FSM states, memory access sizes and the port request record.
package cpu_defs;

    typedef enum logic [2:0] {
        IDLE,
        D_ADDR,
        D_DATA,
        I_ADDR,
        I_DATA
    } arb_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

    localparam int PORT_ADDR_W = 32;
    localparam int PORT_DATA_W = 32;

    typedef struct packed {
        logic                   req;
        logic                   wr;
        mem_size_t              size;
        logic [PORT_ADDR_W-1:0] addr;
        logic [PORT_DATA_W-1:0] wdata;
    } mem_port_req_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch port, data port and shared downstream bus of the memory arbiter.
// master = arbiter side; slave = pipeline stages plus downstream memory.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_busy;
    logic              inst_done;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_busy;
    logic              data_done;

    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_rdata, inst_busy, inst_done,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_busy, data_done,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_rdata, inst_busy, inst_done,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_busy, data_done,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto a single-outstanding SRAM-like bus.
// Optional MEM_ARB_RR_EN: round-robin arbitration instead of fixed data priority.
module mem_bus_arbiter
    import cpu_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            resetn,
    mem_bus_arbiter_if.master mif
);

    arb_state_t        state;
    logic              req_wr;
    mem_size_t         req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              grant_data;
    logic              data_ok_d;
    logic              data_ok_i;

`ifdef MEM_ARB_RR_EN
    // Set when the most recent grant went to the data port; resets to instruction.
    logic              last_grant_data;
    assign grant_data = mif.data_req & (~mif.inst_req | ~last_grant_data);
`else
    assign grant_data = mif.data_req;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            req_wr    <= 1'b0;
            req_size  <= SZ_BYTE;
            req_addr  <= '0;
            req_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_data <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_data) begin
                        state     <= D_ADDR;
                        req_wr    <= mif.data_wr;
                        req_size  <= mem_size_t'(mif.data_size);
                        req_addr  <= mif.data_addr;
                        req_wdata <= mif.data_wdata;
`ifdef MEM_ARB_RR_EN
                        last_grant_data <= 1'b1;
`endif
                    end else if (mif.inst_req) begin
                        state     <= I_ADDR;
                        req_wr    <= 1'b0;
                        req_size  <= SZ_WORD;
                        req_addr  <= mif.inst_addr;
                        req_wdata <= '0;
`ifdef MEM_ARB_RR_EN
                        last_grant_data <= 1'b0;
`endif
                    end
                end
                D_ADDR: if (mif.bus_addr_ok) state <= D_DATA;
                I_ADDR: if (mif.bus_addr_ok) state <= I_DATA;
                // A dropped request still drains its bus transaction here.
                D_DATA: if (mif.bus_data_ok) state <= IDLE;
                I_DATA: if (mif.bus_data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mif.bus_req   = (state == D_ADDR) || (state == I_ADDR);
    assign mif.bus_wr    = req_wr;
    assign mif.bus_size  = req_size;
    assign mif.bus_addr  = req_addr;
    assign mif.bus_wdata = req_wdata;

    assign data_ok_d = (state == D_DATA) && mif.bus_data_ok;
    assign data_ok_i = (state == I_DATA) && mif.bus_data_ok;

    assign mif.data_done  = mif.data_req & data_ok_d;
    assign mif.data_busy  = mif.data_req & ~mif.data_done;
    assign mif.data_rdata = mif.data_done ? mif.bus_rdata : '0;

    assign mif.inst_done  = mif.inst_req & data_ok_i;
    assign mif.inst_busy  = mif.inst_req & ~mif.inst_done;
    assign mif.inst_rdata = mif.inst_done ? mif.bus_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; honours MEM_ARB_RR_EN for the second conflict.
module tb_mem_bus_arbiter;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .mif    (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Entered in the *_ADDR cycle; leaves in the following IDLE cycle with the port's request dropped.
    task automatic serve(input bit is_data, input logic [31:0] exp_addr,
                         input logic [31:0] rd, input string tag);
        check({tag, "_bus_req"}, 32'(mif.bus_req), 32'd1);
        check({tag, "_bus_addr"}, mif.bus_addr, exp_addr);
        mif.bus_addr_ok = 1'b1;
        next_cycle();
        mif.bus_addr_ok = 1'b0;
        mif.bus_data_ok = 1'b1;
        mif.bus_rdata   = rd;
        settle();
        if (is_data) begin
            check({tag, "_data_done"}, 32'(mif.data_done), 32'd1);
            check({tag, "_data_rdata"}, mif.data_rdata, rd);
            check({tag, "_inst_done"}, 32'(mif.inst_done), 32'd0);
        end else begin
            check({tag, "_inst_done"}, 32'(mif.inst_done), 32'd1);
            check({tag, "_inst_rdata"}, mif.inst_rdata, rd);
            check({tag, "_data_done"}, 32'(mif.data_done), 32'd0);
        end
        next_cycle();
        mif.bus_data_ok = 1'b0;
        mif.bus_rdata   = '0;
        if (is_data) mif.data_req = 1'b0;
        else         mif.inst_req = 1'b0;
        settle();
        check({tag, "_idle_bus_req"}, 32'(mif.bus_req), 32'd0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        resetn          = 1'b0;
        mif.inst_req    = 1'b1;
        mif.inst_addr   = '0;
        mif.data_req    = 1'b0;
        mif.data_wr     = 1'b0;
        mif.data_size   = 2'b00;
        mif.data_addr   = '0;
        mif.data_wdata  = '0;
        mif.bus_addr_ok = 1'b0;
        mif.bus_data_ok = 1'b0;
        mif.bus_rdata   = '0;
        #3;
        check("rst_bus_req", 32'(mif.bus_req), 32'd0);
        check("rst_inst_done", 32'(mif.inst_done), 32'd0);
        check("rst_data_done", 32'(mif.data_done), 32'd0);
        check("rst_inst_rdata", mif.inst_rdata, 32'd0);
        check("rst_bus_addr", mif.bus_addr, 32'd0);
        check("rst_bus_wdata", mif.bus_wdata, 32'd0);
        check("rst_inst_busy", 32'(mif.inst_busy), 32'd1);
        check("rst_data_busy", 32'(mif.data_busy), 32'd0);
        mif.inst_req = 1'b0;
        next_cycle();
        resetn = 1'b1;
        next_cycle();

        // Fetch only, minimum latency
        mif.inst_req  = 1'b1;
        mif.inst_addr = 32'hBFC0_0000;
        settle();
        check("f_c0_busy", 32'(mif.inst_busy), 32'd1);
        check("f_c0_bus_req", 32'(mif.bus_req), 32'd0);
        next_cycle();
        check("f_c1_bus_req", 32'(mif.bus_req), 32'd1);
        check("f_c1_bus_addr", mif.bus_addr, 32'hBFC0_0000);
        check("f_c1_bus_wr", 32'(mif.bus_wr), 32'd0);
        check("f_c1_bus_size", 32'(mif.bus_size), 32'd2);
        check("f_c1_busy", 32'(mif.inst_busy), 32'd1);
        mif.bus_addr_ok = 1'b1;
        next_cycle();
        mif.bus_addr_ok = 1'b0;
        mif.bus_data_ok = 1'b1;
        mif.bus_rdata   = 32'h3C08_0001;
        settle();
        check("f_c2_done", 32'(mif.inst_done), 32'd1);
        check("f_c2_rdata", mif.inst_rdata, 32'h3C08_0001);
        check("f_c2_busy", 32'(mif.inst_busy), 32'd0);
        check("f_c2_bus_req", 32'(mif.bus_req), 32'd0);
        next_cycle();
        mif.bus_data_ok = 1'b0;
        mif.inst_req    = 1'b0;
        settle();
        check("f_c3_done", 32'(mif.inst_done), 32'd0);
        check("f_c3_rdata", mif.inst_rdata, 32'd0);

        // Simultaneous requests: data first, fetch waits busy
        mif.data_req  = 1'b1;
        mif.data_wr   = 1'b0;
        mif.data_size = 2'b10;
        mif.data_addr = 32'h8000_1000;
        mif.inst_req  = 1'b1;
        mif.inst_addr = 32'hBFC0_0004;
        settle();
        check("p1_data_busy", 32'(mif.data_busy), 32'd1);
        check("p1_inst_busy", 32'(mif.inst_busy), 32'd1);
        next_cycle();
        check("p1_inst_busy_addr", 32'(mif.inst_busy), 32'd1);
        serve(1'b1, 32'h8000_1000, 32'h1122_3344, "p1_d");
        check("p1_inst_busy_idle", 32'(mif.inst_busy), 32'd1);
        next_cycle();
        serve(1'b0, 32'hBFC0_0004, 32'h2402_0001, "p1_i");

        // Byte store with addr_ok stalled three cycles
        mif.data_req   = 1'b1;
        mif.data_wr    = 1'b1;
        mif.data_size  = 2'b00;
        mif.data_addr  = 32'h8000_0003;
        mif.data_wdata = 32'h0000_00AB;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            check("st_bus_req", 32'(mif.bus_req), 32'd1);
            check("st_bus_wr", 32'(mif.bus_wr), 32'd1);
            check("st_bus_size", 32'(mif.bus_size), 32'd0);
            check("st_bus_addr", mif.bus_addr, 32'h8000_0003);
            check("st_bus_wdata", mif.bus_wdata, 32'h0000_00AB);
            if (i == 3) mif.bus_addr_ok = 1'b1;
            next_cycle();
        end
        mif.bus_addr_ok = 1'b0;
        mif.bus_data_ok = 1'b1;
        mif.bus_rdata   = 32'hDEAD_BEEF;
        settle();
        check("st_data_bus_req", 32'(mif.bus_req), 32'd0);
        check("st_done", 32'(mif.data_done), 32'd1);
        next_cycle();
        mif.bus_data_ok = 1'b0;
        mif.data_req    = 1'b0;
        mif.data_wr     = 1'b0;

        // Second simultaneous pair, directly after a data grant
        mif.data_req  = 1'b1;
        mif.data_size = 2'b01;
        mif.data_addr = 32'h8000_2002;
        mif.inst_req  = 1'b1;
        mif.inst_addr = 32'hBFC0_0008;
        next_cycle();
`ifdef MEM_ARB_RR_EN
        serve(1'b0, 32'hBFC0_0008, 32'h0000_1111, "p2_i");
        next_cycle();
        serve(1'b1, 32'h8000_2002, 32'h0000_2222, "p2_d");
`else
        check("p2_bus_size", 32'(mif.bus_size), 32'd1);
        serve(1'b1, 32'h8000_2002, 32'h0000_2222, "p2_d");
        next_cycle();
        serve(1'b0, 32'hBFC0_0008, 32'h0000_1111, "p2_i");
`endif

        // Load dropped while in D_DATA
        mif.data_req  = 1'b1;
        mif.data_size = 2'b10;
        mif.data_addr = 32'h8000_0010;
        next_cycle();
        mif.bus_addr_ok = 1'b1;
        next_cycle();
        mif.bus_addr_ok = 1'b0;
        mif.data_req    = 1'b0;
        settle();
        check("drop_busy", 32'(mif.data_busy), 32'd0);
        next_cycle();
        mif.bus_data_ok = 1'b1;
        mif.bus_rdata   = 32'h55AA_55AA;
        settle();
        check("drop_done", 32'(mif.data_done), 32'd0);
        check("drop_rdata", mif.data_rdata, 32'd0);
        next_cycle();
        mif.bus_data_ok = 1'b0;
        mif.inst_req    = 1'b1;
        mif.inst_addr   = 32'hBFC0_000C;
        settle();
        check("drop_idle_bus_req", 32'(mif.bus_req), 32'd0);
        next_cycle();
        serve(1'b0, 32'hBFC0_000C, 32'h0000_3333, "drop_i");

        // Reset asserted during I_DATA
        mif.inst_req  = 1'b1;
        mif.inst_addr = 32'hBFC0_0010;
        next_cycle();
        mif.bus_addr_ok = 1'b1;
        next_cycle();
        mif.bus_addr_ok = 1'b0;
        resetn          = 1'b0;
        mif.bus_data_ok = 1'b1;
        mif.bus_rdata   = 32'h1234_5678;
        settle();
        check("rstm_inst_done", 32'(mif.inst_done), 32'd0);
        check("rstm_inst_rdata", mif.inst_rdata, 32'd0);
        check("rstm_inst_busy", 32'(mif.inst_busy), 32'd1);
        check("rstm_bus_req", 32'(mif.bus_req), 32'd0);
        check("rstm_bus_addr", mif.bus_addr, 32'd0);
        next_cycle();
        resetn          = 1'b1;
        mif.bus_data_ok = 1'b0;
        mif.bus_rdata   = '0;
        settle();
        check("rstm_idle_bus_req", 32'(mif.bus_req), 32'd0);
        next_cycle();
        serve(1'b0, 32'hBFC0_0010, 32'h0000_4444, "rstm_i");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
